// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - pixel color type and named colors
package color_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t BLACK = '0;

endpackage

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - display geometry and background renderer configuration
package display_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int N_LAYERS_DEF = 4;
  localparam int STEP_W_DEF   = 4;

  // Renderer configuration as latched at a frame boundary.
  typedef struct packed {
    logic [N_LAYERS_DEF-1:0] mask;
    logic [STEP_W_DEF-1:0]   step;
    logic                    pause;
  } bg_cfg_t;

endpackage

// File: rtl/layer_priority_mux.sv
// rtl/layer_priority_mux.sv - first-one select over layer enables, index 0 wins
module layer_priority_mux
  import color_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  en,
  input  rgb_t [N-1:0]  colors,
  output rgb_t          color,
  output logic [LW-1:0] idx,
  output logic          hit
);

  // Scan from the lowest priority up so the lowest enabled index is the last writer.
  always_comb begin
    color = BLACK;
    idx   = '0;
    hit   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (en[i]) begin
        color = colors[i];
        idx   = LW'(i);
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bg_layer_sequencer.sv
// rtl/bg_layer_sequencer.sv - frame-synchronous scroll/config control and layer compositor
module bg_layer_sequencer
  import color_pkg::*;
#(
  parameter int                N_LAYERS   = 4,
  parameter int                H_ACTIVE   = display_pkg::H_ACTIVE,
  parameter int                STEP_W     = 4,
  parameter logic [N_LAYERS-1:0] RESET_MASK = '1,
  parameter int                LW         = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                de,
  input  logic                vsync,
  output logic [9:0]          x_scr,
  input  logic [N_LAYERS-1:0] layer_en,
  input  rgb_t [N_LAYERS-1:0] layer_color,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [N_LAYERS-1:0] cfg_mask,
  input  logic [STEP_W-1:0]   cfg_step,
  input  logic                cfg_pause,
  output logic [9:0]          scroll_x,
  output logic [15:0]         frame_cnt,
  output rgb_t                out_color,
  output logic                out_de,
  output logic [LW-1:0]       out_layer,
  output logic                out_hit
);

  display_pkg::bg_cfg_t active_q, active_d, shadow_q, shadow_d;
  logic                 vsync_q, vsync_d, pending_q, pending_d;
  logic [9:0]           scroll_q, scroll_d;
  logic [15:0]          frame_q, frame_d;
  logic                 tick, cfg_accept;
  logic [10:0]          x_sum, s_sum;

  logic [N_LAYERS-1:0]  en_s1_q, en_s1_d;
  rgb_t [N_LAYERS-1:0]  col_s1_q, col_s1_d;
  logic                 de_s1_q, de_s1_d;
  rgb_t                 out_color_q, out_color_d, mux_color;
  logic [LW-1:0]        out_layer_q, out_layer_d, mux_idx;
  logic                 out_de_q, out_de_d, out_hit_q, out_hit_d, mux_hit;

  // y is carried for renderer alignment only; nothing here depends on it.
  logic unused_y;
  assign unused_y = ^y;

  assign tick       = vsync & ~vsync_q;
  assign cfg_ready  = ~pending_q;
  assign cfg_accept = cfg_valid & ~pending_q;
  assign scroll_x   = scroll_q;
  assign frame_cnt  = frame_q;

  // Scrolled x for the renderers: one conditional subtract wraps into the visible range.
  always_comb begin
    x_sum = {1'b0, x} + {1'b0, scroll_q};
    x_scr = (x_sum >= 11'(H_ACTIVE)) ? 10'(x_sum - 11'(H_ACTIVE)) : x_sum[9:0];
  end

  // Frame-boundary logic: shadow capture, scroll advance with the old config, then config swap.
  always_comb begin
    vsync_d   = vsync;
    scroll_d  = scroll_q;
    frame_d   = frame_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    s_sum     = {1'b0, scroll_q} + 11'(active_q.step);
    if (cfg_accept) begin
      shadow_d  = '{mask: cfg_mask, step: cfg_step, pause: cfg_pause};
      pending_d = 1'b1;
    end
    if (tick) begin
      frame_d = frame_q + 16'd1;
      if (!active_q.pause) begin
        scroll_d = (s_sum >= 11'(H_ACTIVE)) ? 10'(s_sum - 11'(H_ACTIVE)) : s_sum[9:0];
      end
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  layer_priority_mux #(.N(N_LAYERS), .LW(LW)) u_mux (
    .en     (en_s1_q),
    .colors (col_s1_q),
    .color  (mux_color),
    .idx    (mux_idx),
    .hit    (mux_hit)
  );

  // Two-stage compositor: S1 masks and aligns, S2 registers the winning layer.
  always_comb begin
    en_s1_d     = layer_en & active_q.mask;
    col_s1_d    = layer_color;
    de_s1_d     = de;
    out_de_d    = de_s1_q;
    out_color_d = BLACK;
    out_layer_d = '0;
    out_hit_d   = 1'b0;
    if (de_s1_q && mux_hit) begin
      out_color_d = mux_color;
      out_layer_d = mux_idx;
      out_hit_d   = 1'b1;
    end
  end

  // State registers; reset aborts any pixels in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      scroll_q    <= '0;
      frame_q     <= '0;
      active_q    <= '{mask: RESET_MASK, step: '0, pause: 1'b0};
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      en_s1_q     <= '0;
      col_s1_q    <= '0;
      de_s1_q     <= 1'b0;
      out_color_q <= BLACK;
      out_de_q    <= 1'b0;
      out_layer_q <= '0;
      out_hit_q   <= 1'b0;
    end else begin
      vsync_q     <= vsync_d;
      scroll_q    <= scroll_d;
      frame_q     <= frame_d;
      active_q    <= active_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      en_s1_q     <= en_s1_d;
      col_s1_q    <= col_s1_d;
      de_s1_q     <= de_s1_d;
      out_color_q <= out_color_d;
      out_de_q    <= out_de_d;
      out_layer_q <= out_layer_d;
      out_hit_q   <= out_hit_d;
    end
  end

  assign out_color = out_color_q;
  assign out_de    = out_de_q;
  assign out_layer = out_layer_q;
  assign out_hit   = out_hit_q;

endmodule
